// File: rtl/lsu_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module      : lsu_bus_bridge
// Description : Load/store bridge from the RV32I datapath data-memory port to
//               a request/grant/response data bus. Converts each access into
//               a word-aligned bus transaction with byte enables and returns
//               a sign- or zero-extended load result. Holds the core with
//               stall_o while the access is in flight.
// Ports       : clk, reset            - clock, async active-high reset
//               mem_address_i         - byte address
//               wr_width_i            - funct3 access width/signedness
//               mem_read_ctrl_i       - load strobe
//               mem_write_ctrl_i      - store strobe (wins over load)
//               mem_write_data_i      - store data
//               mem_read_data_o       - registered extended load result
//               stall_o               - hold PC / suppress regfile write
//               misalign_o, err_o     - one-cycle status pulses
//               bus_req_o .. bus_wdata_o - bus request channel
//               bus_gnt_i, bus_rvalid_i, bus_rdata_i - bus responses
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_bus_bridge #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_address_i,
    input  logic [2:0]  wr_width_i,
    input  logic        mem_read_ctrl_i,
    input  logic        mem_write_ctrl_i,
    input  logic [31:0] mem_write_data_i,
    output logic [31:0] mem_read_data_o,
    output logic        stall_o,
    output logic        misalign_o,
    output logic        err_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_req    = 2'd1;
    localparam logic [1:0] c_st_wait_r = 2'd2;
    localparam logic [1:0] c_st_done   = 2'd3;

    localparam logic [15:0] c_timeout = 16'(TIMEOUT_CYCLES);

    logic [1:0]  r_state;
    logic [15:0] r_cnt;
    logic        r_we;
    logic [2:0]  r_width;
    logic [1:0]  r_off;
    logic [31:0] r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_misalign;
    logic        r_err;

    logic        w_access;
    logic        w_is_byte;
    logic        w_is_half;
    logic        w_misaligned;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_lane_b;
    logic [15:0] w_lane_h;
    logic [31:0] w_load_ext;
    logic [15:0] w_cnt_inc;
    logic        w_timeout;

    // Request-side decode of the incoming datapath access.
    always_comb begin
        w_access     = mem_read_ctrl_i | mem_write_ctrl_i;
        // Bit 2 only selects signedness; unlisted codes fall through to word.
        w_is_byte    = (wr_width_i[1:0] == 2'b00);
        w_is_half    = (wr_width_i[1:0] == 2'b01);
        w_misaligned = (w_is_half & mem_address_i[0]) |
                       (~w_is_byte & ~w_is_half & (mem_address_i[1:0] != 2'b00));
        if (w_is_byte) begin
            w_be    = 4'b0001 << mem_address_i[1:0];
            w_wdata = {4{mem_write_data_i[7:0]}};
        end else if (w_is_half) begin
            w_be    = 4'b0011 << mem_address_i[1:0];
            w_wdata = {2{mem_write_data_i[15:0]}};
        end else begin
            w_be    = 4'b1111;
            w_wdata = mem_write_data_i;
        end
    end

    // Response-side lane extraction using the captured offset and width.
    always_comb begin
        case (r_off)
            2'd0:    w_lane_b = bus_rdata_i[7:0];
            2'd1:    w_lane_b = bus_rdata_i[15:8];
            2'd2:    w_lane_b = bus_rdata_i[23:16];
            default: w_lane_b = bus_rdata_i[31:24];
        endcase
        w_lane_h = r_off[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
        case (r_width)
            3'b000:  w_load_ext = {{24{w_lane_b[7]}}, w_lane_b};
            3'b100:  w_load_ext = {24'h0, w_lane_b};
            3'b001:  w_load_ext = {{16{w_lane_h[15]}}, w_lane_h};
            3'b101:  w_load_ext = {16'h0, w_lane_h};
            default: w_load_ext = bus_rdata_i;
        endcase
        w_cnt_inc = r_cnt + 16'd1;
        // Fires on the cycle that would bring the count up to the limit, so
        // the access spends exactly TIMEOUT_CYCLES cycles on the bus.
        w_timeout = (w_cnt_inc == c_timeout);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= c_st_idle;
            r_cnt      <= 16'd0;
            r_we       <= 1'b0;
            r_width    <= 3'b000;
            r_off      <= 2'b00;
            r_addr     <= 32'h0;
            r_be       <= 4'h0;
            r_wdata    <= 32'h0;
            r_rdata    <= 32'h0;
            r_misalign <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            // Status flags are only ever set on entry to DONE, which lasts
            // a single cycle, so they naturally form one-cycle pulses.
            r_misalign <= 1'b0;
            r_err      <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    r_cnt <= 16'd0;
                    if (w_access) begin
                        r_we    <= mem_write_ctrl_i;
                        r_width <= wr_width_i;
                        r_off   <= mem_address_i[1:0];
                        r_addr  <= {mem_address_i[31:2], 2'b00};
                        r_be    <= w_be;
                        r_wdata <= w_wdata;
                        if (w_misaligned) begin
                            r_state    <= c_st_done;
                            r_misalign <= 1'b1;
                            if (!mem_write_ctrl_i) begin
                                r_rdata <= 32'h0;
                            end
                        end else begin
                            r_state <= c_st_req;
                        end
                    end
                end
                c_st_req: begin
                    r_cnt <= w_cnt_inc;
                    // A grant in the final cycle still completes the access.
                    if (bus_gnt_i) begin
                        r_state <= r_we ? c_st_done : c_st_wait_r;
                    end else if (w_timeout) begin
                        r_state <= c_st_done;
                        r_err   <= 1'b1;
                        if (!r_we) begin
                            r_rdata <= 32'h0;
                        end
                    end
                end
                c_st_wait_r: begin
                    r_cnt <= w_cnt_inc;
                    if (bus_rvalid_i) begin
                        r_rdata <= w_load_ext;
                        r_state <= c_st_done;
                    end else if (w_timeout) begin
                        r_state <= c_st_done;
                        r_err   <= 1'b1;
                        r_rdata <= 32'h0;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // Stall is raised combinationally in IDLE so the instruction presenting
    // the access is held from its very first cycle; DONE releases it.
    assign stall_o         = ((r_state == c_st_idle) & w_access) |
                             (r_state == c_st_req) | (r_state == c_st_wait_r);
    assign bus_req_o       = (r_state == c_st_req);
    assign bus_we_o        = r_we;
    assign bus_addr_o      = r_addr;
    assign bus_be_o        = r_be;
    assign bus_wdata_o     = r_wdata;
    assign mem_read_data_o = r_rdata;
    assign misalign_o      = r_misalign;
    assign err_o           = r_err;

endmodule
`default_nettype wire
